v74x148_serial_encoder: RTL and testbench
=========================================

Name: v74x148_serial_encoder

Overview:
Sequential counterpart to the dual 2-to-4 decoder: an N-to-log2(N) priority encoder in 74x148 style with active-low I/O.
- Captures an active-low request vector on a LOAD strobe.
- Emits the encoded index of every asserted request, one per accepted transfer, in priority order.
- Uses a GS_L/READY handshake.
- Sits in front of the decoder path, so a decoder fed from A_L regenerates a one-hot select for each captured request.

Parameters:
N, 8, number of request inputs (power of two, 2..64).
W, $clog2(N), code width; derived, not overridden.
PRIORITY_HIGH, 1, 1 = highest index served first (74x148 order); 0 = lowest index first.

Ports:
CLK  in  1  rising-edge clock.
RESET  in  1  asynchronous, active-high reset.
G_L  in  1  enable, active low; high blocks capture and aborts emission.
I_L  in  N  request inputs, active low (bit i low = request i).
LOAD  in  1  capture strobe, sampled at CLK edge.
READY  in  1  consumer accepts current code when GS_L=0 and READY=1 at a CLK edge.
A_L  out  W  encoded index, active low (A_L = ~index); all ones when idle.
GS_L  out  1  group select, active low: A_L holds a valid code.
EO_L  out  1  enable-out, active low: one-cycle pulse when an enabled capture found no requests.
BUSY  out  1  high while captured requests remain.
DONE  out  1  one-cycle pulse after the last code is accepted.

Behaviour:
- All outputs are registered.
- RESET=1 (async) forces:
  - state IDLE, pending mask 0;
  - A_L all ones, GS_L=1, EO_L=1, BUSY=0, DONE=0.
- State machine: IDLE, EMIT.
- IDLE:
  - GS_L=1, A_L all ones, BUSY=0.
  - On an edge with LOAD=1 and G_L=0, pend <= ~I_L.
  - If ~I_L is nonzero: go to EMIT. At that same edge, A_L <= ~prio(~I_L), GS_L <= 0, BUSY <= 1. Latency from LOAD edge to valid code is one edge.
  - If ~I_L is zero: stay IDLE, EO_L <= 0 for exactly one cycle.
  - LOAD with G_L=1: ignored, no output change.
- EMIT:
  - A_L and GS_L hold stable while READY=0.
  - On accept (READY=1), the served bit is cleared: pend_next = pend & ~onehot(code).
    - pend_next nonzero: A_L <= ~prio(pend_next), GS_L stays 0. Back-to-back codes at full rate, one per cycle with READY held high.
    - pend_next zero: GS_L <= 1, A_L <= all ones, BUSY <= 0, DONE <= 1 for one cycle, go to IDLE.
  - LOAD in EMIT is ignored. A new capture is possible on the cycle after DONE, when the state is IDLE.
  - G_L=1 at an edge in EMIT aborts:
    - pend <= 0, go to IDLE, GS_L <= 1, A_L all ones, BUSY <= 0;
    - DONE stays 0, EO_L stays 1;
    - abort takes precedence over a simultaneous accept.
- prio(): picks the highest set index if PRIORITY_HIGH=1, otherwise the lowest set index.
- EO_L, DONE: never asserted in the same cycle; each is high except for its single-cycle pulse.
- I_L changes after capture have no effect until the next capture.

Decomposition:
- Package v74x148_pkg:
  - state enum {IDLE, EMIT};
  - function clog2 for W;
  - localparams for idle output values (A_L all ones, GS_L=1).
- One combinational sub-module: v74x148_prio.
  - Inputs: N-bit active-high request.
  - Outputs: W-bit index, found flag, N-bit one-hot of the served bit.
  - Parameter: PRIORITY_HIGH.
- The top module holds the FSM, pend register and output registers.

Test Plan:
1. Reset: RESET=1 at any point -> immediately A_L=111, GS_L=1, EO_L=1, BUSY=0, DONE=0 without a clock edge.
2. Full-rate drain: G_L=0, I_L=8'b0101_1011 (requests 7,5,2), LOAD one cycle, READY=1 -> A_L=000, 010, 101 on three consecutive cycles with GS_L=0. On the next cycle DONE=1 for one cycle, GS_L=1, BUSY=0.
3. Backpressure: same capture, READY=0 for 3 cycles -> A_L holds 000, GS_L=0. Then READY=1 -> 010 next.
4. Empty capture: G_L=0, I_L=8'hFF, LOAD -> EO_L=0 for exactly one cycle, GS_L=1, BUSY=0. Also: LOAD with G_L=1, I_L=8'h00 -> no output change.
5. Abort and ignore: capture I_L=8'h00 (all 8 requests). After 2 accepts, assert LOAD with a new vector -> ignored. Then G_L=1 -> next cycle GS_L=1, A_L=111, BUSY=0, no DONE.
6. Low-first order plus mid-EMIT reset: PRIORITY_HIGH=0, I_L=8'b0101_1011 -> codes A_L=101, 010, 000. RESET mid-EMIT -> reset values, and a fresh capture afterwards works normally.

Source files
------------

// File: rtl/v74x148_pkg.sv
// Shared types and constants for the 74x148-style serial priority encoder.
package v74x148_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Code width for an n-input encoder (n a power of two, 2..64).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  // Sliced to W bits by the user; wide enough for the largest supported N.
  localparam logic [63:0] A_L_IDLE_ALL = '1;
  localparam logic        GS_L_IDLE    = 1'b1;
  localparam logic        EO_L_IDLE    = 1'b1;

endpackage

// File: rtl/v74x148_prio.sv
// Combinational priority picker: index, found flag and one-hot of the winning request.
module v74x148_prio #(
  parameter int N             = 8,
  parameter int W             = 3,
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found,
  output logic [N-1:0] onehot
);

  // The last match in scan order wins, so scan away from the preferred end.
  always_comb begin
    idx    = '0;
    found  = 1'b0;
    onehot = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          idx    = W'(i);
          found  = 1'b1;
          onehot = N'(1) << i;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req[i]) begin
          idx    = W'(i);
          found  = 1'b1;
          onehot = N'(1) << i;
        end
      end
    end
  end

endmodule

// File: rtl/v74x148_serial_encoder.sv
// Captures an active-low request vector on LOAD and emits one active-low code per
// accepted GS_L/READY transfer, in priority order; G_L high blocks capture and aborts.
module v74x148_serial_encoder
  import v74x148_pkg::*;
#(
  parameter int N             = 8,
  parameter bit PRIORITY_HIGH = 1'b1,
  localparam int W            = clog2(N)
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         G_L,
  input  logic [N-1:0] I_L,
  input  logic         LOAD,
  input  logic         READY,
  output logic [W-1:0] A_L,
  output logic         GS_L,
  output logic         EO_L,
  output logic         BUSY,
  output logic         DONE
);

  localparam logic [W-1:0] A_L_IDLE = A_L_IDLE_ALL[W-1:0];

  state_e         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic [W-1:0]   a_l_q, a_l_d;
  logic           gs_l_q, gs_l_d;
  logic           eo_l_q, eo_l_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0]   prio_req;
  logic [W-1:0]   prio_idx;
  logic           prio_found;
  logic [N-1:0]   prio_onehot;

  // pend_q holds the requests still owed *after* the code currently on A_L, so a
  // single picker serves both the capture and every accept.
  assign prio_req = (state_q == IDLE) ? ~I_L : pend_q;

  v74x148_prio #(
    .N             (N),
    .W             (W),
    .PRIORITY_HIGH (PRIORITY_HIGH)
  ) u_prio (
    .req    (prio_req),
    .idx    (prio_idx),
    .found  (prio_found),
    .onehot (prio_onehot)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    a_l_d   = a_l_q;
    gs_l_d  = gs_l_q;
    eo_l_d  = EO_L_IDLE;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (LOAD && !G_L) begin
          if (prio_found) begin
            state_d = EMIT;
            pend_d  = prio_req & ~prio_onehot;
            a_l_d   = ~prio_idx;
            gs_l_d  = 1'b0;
            busy_d  = 1'b1;
          end else begin
            pend_d  = '0;
            eo_l_d  = 1'b0;
          end
        end
      end
      EMIT: begin
        if (G_L) begin
          state_d = IDLE;
          pend_d  = '0;
          a_l_d   = A_L_IDLE;
          gs_l_d  = GS_L_IDLE;
          busy_d  = 1'b0;
        end else if (READY) begin
          if (prio_found) begin
            pend_d = pend_q & ~prio_onehot;
            a_l_d  = ~prio_idx;
          end else begin
            state_d = IDLE;
            a_l_d   = A_L_IDLE;
            gs_l_d  = GS_L_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      pend_q  <= '0;
      a_l_q   <= A_L_IDLE;
      gs_l_q  <= GS_L_IDLE;
      eo_l_q  <= EO_L_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      a_l_q   <= a_l_d;
      gs_l_q  <= gs_l_d;
      eo_l_q  <= eo_l_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A_L  = a_l_q;
  assign GS_L = gs_l_q;
  assign EO_L = eo_l_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_v74x148_serial_encoder.sv
// Directed bench with a code scoreboard, covering high-first and low-first encoders.
module tb_v74x148_serial_encoder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       G_L;
  logic [7:0] I_L;
  logic       LOAD;
  logic       READY;

  logic [2:0] a_hi, a_lo;
  logic       gs_hi, eo_hi, busy_hi, done_hi;
  logic       gs_lo, eo_lo, busy_lo, done_lo;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] exp_q[$];

  v74x148_serial_encoder #(.N(8), .PRIORITY_HIGH(1'b1)) dut_hi (
    .CLK(CLK), .RESET(RESET), .G_L(G_L), .I_L(I_L), .LOAD(LOAD), .READY(READY),
    .A_L(a_hi), .GS_L(gs_hi), .EO_L(eo_hi), .BUSY(busy_hi), .DONE(done_hi)
  );

  v74x148_serial_encoder #(.N(8), .PRIORITY_HIGH(1'b0)) dut_lo (
    .CLK(CLK), .RESET(RESET), .G_L(G_L), .I_L(I_L), .LOAD(LOAD), .READY(READY),
    .A_L(a_lo), .GS_L(gs_lo), .EO_L(eo_lo), .BUSY(busy_lo), .DONE(done_lo)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference order: every low bit of il, as active-low codes, preferred end first.
  task automatic push_model(input logic [7:0] il, input bit high);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = high ? 7 - k : k;
      if (!il[i]) exp_q.push_back(~3'(i));
    end
  endtask

  task automatic drain(input bit lo);
    logic [2:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("code", lo ? a_lo : a_hi, e);
      chk("gs_emit", lo ? gs_lo : gs_hi, 0);
      chk("busy_emit", lo ? busy_lo : busy_hi, 1);
      tick();
    end
    chk("done_pulse", lo ? done_lo : done_hi, 1);
    chk("gs_after", lo ? gs_lo : gs_hi, 1);
    chk("busy_after", lo ? busy_lo : busy_hi, 0);
    chk("a_after", lo ? a_lo : a_hi, 3'b111);
    tick();
    chk("done_one_cycle", lo ? done_lo : done_hi, 0);
  endtask

  initial begin
    RESET = 1'b0; G_L = 1'b1; LOAD = 1'b0; READY = 1'b0; I_L = 8'hFF;

    // Asynchronous reset, observed before any clock edge
    #1 RESET = 1'b1;
    #1;
    chk("rst_a", a_hi, 3'b111);
    chk("rst_gs", gs_hi, 1);
    chk("rst_eo", eo_hi, 1);
    chk("rst_busy", busy_hi, 0);
    chk("rst_done", done_hi, 0);
    tick();
    RESET = 1'b0;
    tick();

    // Full-rate drain of requests 7,5,2
    G_L = 1'b0; I_L = 8'b0101_1011; LOAD = 1'b1; READY = 1'b1;
    push_model(I_L, 1'b1);
    tick();
    LOAD = 1'b0;
    drain(1'b0);

    // Backpressure: code holds while READY is low
    I_L = 8'b0101_1011; LOAD = 1'b1; READY = 1'b0;
    push_model(I_L, 1'b1);
    tick();
    LOAD = 1'b0;
    repeat (3) begin
      chk("hold_code", a_hi, exp_q[0]);
      chk("hold_gs", gs_hi, 0);
      tick();
    end
    READY = 1'b1;
    drain(1'b0);

    // Empty capture pulses EO_L for one cycle
    I_L = 8'hFF; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("eo_pulse", eo_hi, 0);
    chk("eo_gs", gs_hi, 1);
    chk("eo_busy", busy_hi, 0);
    chk("eo_done", done_hi, 0);
    tick();
    chk("eo_one_cycle", eo_hi, 1);

    // Disabled capture is ignored
    G_L = 1'b1; I_L = 8'h00; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("dis_gs", gs_hi, 1);
    chk("dis_a", a_hi, 3'b111);
    chk("dis_busy", busy_hi, 0);
    chk("dis_eo", eo_hi, 1);
    tick();
    chk("dis_gs2", gs_hi, 1);

    // All eight requests, LOAD ignored mid-EMIT, then abort
    G_L = 1'b0; I_L = 8'h00; LOAD = 1'b1; READY = 1'b1;
    push_model(I_L, 1'b1);
    tick();
    LOAD = 1'b0;
    chk("ab_code0", a_hi, exp_q.pop_front());
    tick();
    chk("ab_code1", a_hi, exp_q.pop_front());
    tick();
    chk("ab_code2", a_hi, exp_q[0]);
    I_L = 8'hFE; LOAD = 1'b1; READY = 1'b0;
    tick();
    LOAD = 1'b0;
    chk("ign_code", a_hi, exp_q[0]);
    chk("ign_busy", busy_hi, 1);
    G_L = 1'b1;
    tick();
    chk("abort_gs", gs_hi, 1);
    chk("abort_a", a_hi, 3'b111);
    chk("abort_busy", busy_hi, 0);
    chk("abort_done", done_hi, 0);
    chk("abort_eo", eo_hi, 1);
    tick();
    chk("abort_done2", done_hi, 0);
    exp_q.delete();

    // Low-first order, interrupted by reset
    G_L = 1'b0; I_L = 8'b0101_1011; LOAD = 1'b1; READY = 1'b1;
    push_model(I_L, 1'b0);
    tick();
    LOAD = 1'b0;
    chk("lo_code0", a_lo, exp_q.pop_front());
    tick();
    chk("lo_code1", a_lo, exp_q.pop_front());
    RESET = 1'b1;
    #1;
    chk("mid_rst_a", a_lo, 3'b111);
    chk("mid_rst_gs", gs_lo, 1);
    chk("mid_rst_busy", busy_lo, 0);
    chk("mid_rst_done", done_lo, 0);
    chk("mid_rst_eo", eo_lo, 1);
    exp_q.delete();
    tick();
    RESET = 1'b0;
    tick();

    // Fresh low-first capture after reset
    I_L = 8'b0101_1011; LOAD = 1'b1;
    push_model(I_L, 1'b0);
    tick();
    LOAD = 1'b0;
    drain(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
